seq_right_shifter: RTL and testbench
====================================

// Module: seq_right_shifter
// PURPOSE
//  Multi-cycle right shifter for the RV64 datapath (SRL/SRA; SRLW/SRAW when the
//  optional feature is compiled in). Complements the combinational left_lshifter:
//  the operand is shifted right, one log2 stage per cycle, under a start/done handshake.
//  Sits beside the ALU. The execute stage stalls on busy and consumes S on done.
// PARAMETERS
//  WIDTH  64  operand/result width; must be a power of 2, >= 8
//  SHW    $clog2(WIDTH) (localparam)  shift-amount bits used; also latency in cycles
// PORTS
//  clk    in   1      rising-edge clock
//  reset  in   1      asynchronous, active-high reset
//  start  in   1      request; sampled only in IDLE or DONE
//  A      in   WIDTH  operand to shift, captured on accepted start
//  B      in   WIDTH  shift amount; only B[SHW-1:0] used, captured on accepted start
//  arith  in   1      1 = arithmetic (sign fill), 0 = logical (zero fill); captured
//  word   in   1      (RSHIFT_WORD_OP_EN only) 1 = 32-bit word op; captured
//  S      out  WIDTH  result; valid from done cycle until next accepted start
//  busy   out  1      high while shifting
//  done   out  1      single-cycle pulse when S becomes valid
// BEHAVIOUR
//  - Reset (any time, incl. mid-operation): state=IDLE, S=0, busy=0, done=0,
//    internal operand/amount/stage counter cleared. No partial result escapes.
//  - FSM: IDLE --start--> SHIFT --after SHW stages--> DONE
//    DONE --start--> SHIFT; DONE --!start--> IDLE.
//  - Accept: at edge N, state IDLE or DONE and start=1 -> latch A, B[SHW-1:0], arith
//    (and word); load stage index k=SHW-1; busy=1 after edge N. done drops to 0.
//  - SHIFT: each edge N+1..N+SHW processes stage k (k = SHW-1 down to 0):
//    if amt[k] then op = op >> 2**k, filling vacated MSBs with fill bit; k decrements.
//  - Fill bit = arith ? op_sign : 0, where op_sign is the sign of the captured operand
//    (A[WIDTH-1]; A[31] in word mode). Fill is constant for the whole operation.
//  - Completion: at edge N+SHW, S <= shifted value, busy=0, done=1 for exactly one cycle.
//    Latency is fixed at SHW cycles (6 for WIDTH=64) regardless of amount.
//  - start while busy: ignored. No queueing. Captured operands unaffected.
//  - start in DONE cycle: accepted (back-to-back). done is high that cycle; S is updated
//    again SHW cycles later. S holds the previous result while busy.
//  - Amount 0: S=A after full latency. B >= WIDTH: wraps modulo WIDTH (upper bits ignored).
//  - A/B/arith may change freely after accept without effect.
// CONFIGURATION
//  RSHIFT_WORD_OP_EN defined: port word exists. If word=1, the operand is A[31:0],
//    the amount is B[4:0] (amt[SHW-1:5] forced 0), and the fill and sign come from A[31].
//    S = {{(WIDTH-32){res[31]}}, res[31:0]}. Latency stays SHW. Requires WIDTH=64.
//    If word=0, behaviour is identical to the build without the macro.
//  RSHIFT_WORD_OP_EN undefined: no word port; every operation is a full-WIDTH shift.
// TESTING (WIDTH=64)
//  1. A=64'h8000_0000_0000_0000, B=63, arith=0, 1-cycle start -> busy 6 cycles;
//     done pulses at edge 6 with S=64'h1; done low the next cycle.
//  2. Same A, B=63, arith=1 -> S=64'hFFFF_FFFF_FFFF_FFFF. B=0 -> S=A.
//     B=64 (wraps to 0) -> S=A. All complete at latency 6.
//  3. Start A=64'hF0, B=4. Pulse start again mid-op with A=0. -> second start ignored;
//     S=64'hF. Then start held high through DONE -> new op accepted back-to-back.
//  4. Assert reset at cycle 3 of an op -> S=0, busy=0, done=0 immediately (async).
//     No done pulse follows. Next start behaves normally.
//  5. Sweep B=0..63 on A=64'hA5A5_5A5A_F00F_0FF0, both arith values
//     -> S equals A>>B or $signed(A)>>>B every time. Count errors.
//  6. (RSHIFT_WORD_OP_EN) A=64'h0000_0000_8000_0000, B=4, arith=1, word=1
//     -> S=64'hFFFF_FFFF_F800_0000. B=36, arith=0 -> S=64'h0000_0000_0800_0000.

Source files
------------

// File: rtl/seq_right_shifter.sv
`default_nettype none
// ============================================================================
// Module      : seq_right_shifter
// Description : Multi-cycle right shifter (logical or arithmetic) that
//               processes one log2 stage per cycle under a start/done
//               handshake. Latency is always SHW cycles.
//               Optional macro RSHIFT_WORD_OP_EN adds a 32-bit word-op
//               mode through the 'word' port.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_right_shifter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             arith,
`ifdef RSHIFT_WORD_OP_EN
    input  logic             word,
`endif
    output logic [WIDTH-1:0] S,
    output logic             busy,
    output logic             done
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_op;
    logic [SHW-1:0]     r_amt;
    logic [SHW-1:0]     r_k;
    logic               r_fill;
    logic [WIDTH-1:0]   r_s;

    logic               w_accept;
    logic [SHW-1:0]     w_dist;
    logic [2*WIDTH-1:0] w_ext;
    logic [2*WIDTH-1:0] w_ext_sh;
    logic [WIDTH-1:0]   w_next_op;
    logic [WIDTH-1:0]   w_res;
    logic [WIDTH-1:0]   w_load_op;
    logic [SHW-1:0]     w_load_amt;
    logic               w_load_fill;
    logic               w_unused_b;

    // Upper amount bits are intentionally ignored (amount wraps modulo WIDTH).
    assign w_unused_b = ^B[WIDTH-1:SHW];

    // A new operation is only taken when no shift is in flight.
    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

`ifdef RSHIFT_WORD_OP_EN
    logic r_word;

    // Word mode pre-fills the upper half with the fill bit so a full-width
    // shift leaves the correct 32-bit result in the low half.
    always_comb begin
        w_load_fill = 1'b0;
        w_load_op   = A;
        w_load_amt  = B[SHW-1:0];
        if (word) begin
            w_load_fill = arith & A[31];
            w_load_op   = {{(WIDTH-32){arith & A[31]}}, A[31:0]};
            w_load_amt  = SHW'(B[4:0]);
        end else begin
            w_load_fill = arith & A[WIDTH-1];
        end
    end

    assign w_res = r_word ? {{(WIDTH-32){w_next_op[31]}}, w_next_op[31:0]} : w_next_op;
`else
    assign w_load_fill = arith & A[WIDTH-1];
    assign w_load_op   = A;
    assign w_load_amt  = B[SHW-1:0];
    assign w_res       = w_next_op;
`endif

    // One stage: shift by 2**k with the captured fill bit entering from the top.
    assign w_dist    = SHW'(1) << r_k;
    assign w_ext     = {{WIDTH{r_fill}}, r_op};
    assign w_ext_sh  = w_ext >> w_dist;
    assign w_next_op = r_amt[r_k] ? w_ext_sh[WIDTH-1:0] : r_op;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_SHIFT;
            ST_SHIFT: if (r_k == '0) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = start ? ST_SHIFT : ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: capture on accept, one stage per SHIFT cycle, publish on last stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op   <= '0;
            r_amt  <= '0;
            r_k    <= '0;
            r_fill <= 1'b0;
            r_s    <= '0;
`ifdef RSHIFT_WORD_OP_EN
            r_word <= 1'b0;
`endif
        end else if (w_accept) begin
            r_op   <= w_load_op;
            r_amt  <= w_load_amt;
            r_k    <= SHW'(SHW-1);
            r_fill <= w_load_fill;
`ifdef RSHIFT_WORD_OP_EN
            r_word <= word;
`endif
        end else if (r_state == ST_SHIFT) begin
            r_op <= w_next_op;
            r_k  <= r_k - 1'b1;
            if (r_k == '0) begin
                r_s <= w_res;
            end
        end
    end

    assign S    = r_s;
    assign busy = (r_state == ST_SHIFT);
    assign done = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_seq_right_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_right_shifter
// Description : Directed self-checking bench for seq_right_shifter (WIDTH=64).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_right_shifter;

    logic        clk;
    logic        reset;
    logic        start;
    logic [63:0] A;
    logic [63:0] B;
    logic        arith;
    logic        word;
    logic [63:0] S;
    logic        busy;
    logic        done;

    int errors;
    int checks;

    seq_right_shifter #(.WIDTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .arith (arith),
`ifdef RSHIFT_WORD_OP_EN
        .word  (word),
`endif
        .S     (S),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation, scramble inputs after accept, wait for done.
    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic ar,
                         input logic w, output logic [63:0] s, output int lat);
        @(negedge clk);
        A = a; B = b; arith = ar; word = w; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = ~a; B = ~b; arith = ~ar; word = ~w;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        s = S;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; A = '0; B = '0; arith = 1'b0; word = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (S !== 64'h0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: S=%h busy=%b done=%b, want 0/0/0", S, busy, done);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [63:0] s;
        int lat;
        do_op(64'h8000_0000_0000_0000, 64'd63, 1'b0, 1'b0, s, lat);
        checks++;
        if (s !== 64'h1 || lat != 6) begin
            errors++;
            $display("FAIL srl_63: S=%h lat=%0d, want 1 lat 6", s, lat);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b one cycle later, want 0", done);
        end
        do_op(64'h8000_0000_0000_0000, 64'd63, 1'b1, 1'b0, s, lat);
        checks++;
        if (s !== 64'hFFFF_FFFF_FFFF_FFFF || lat != 6) begin
            errors++;
            $display("FAIL sra_63: S=%h lat=%0d, want ffffffffffffffff lat 6", s, lat);
        end
        do_op(64'h8000_0000_0000_0000, 64'd0, 1'b1, 1'b0, s, lat);
        checks++;
        if (s !== 64'h8000_0000_0000_0000 || lat != 6) begin
            errors++;
            $display("FAIL amt_0: S=%h lat=%0d, want 8000000000000000 lat 6", s, lat);
        end
        do_op(64'h8000_0000_0000_0000, 64'd64, 1'b1, 1'b0, s, lat);
        checks++;
        if (s !== 64'h8000_0000_0000_0000 || lat != 6) begin
            errors++;
            $display("FAIL amt_64_wrap: S=%h lat=%0d, want 8000000000000000 lat 6", s, lat);
        end
    endtask

    task automatic test_ignore_busy();
        int lat;
        @(negedge clk);
        A = 64'hF0; B = 64'd4; arith = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_accept: busy=%b, want 1", busy);
        end
        @(negedge clk);
        A = 64'h0; B = 64'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 2;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (S !== 64'hF || lat != 6) begin
            errors++;
            $display("FAIL ignore_busy_start: S=%h lat=%0d, want f lat 6", S, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        // Called while done is high from the previous test.
        A = 64'h1234_5678_9ABC_DEF0; B = 64'd8; arith = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || S !== 64'hF) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b S=%h, want 1 and held f", busy, S);
        end
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (S !== 64'h0012_3456_789A_BCDE || lat != 6) begin
            errors++;
            $display("FAIL b2b_result: S=%h lat=%0d, want 00123456789abcde lat 6", S, lat);
        end
    endtask

    task automatic test_async_reset();
        logic [63:0] s;
        int lat;
        int seen;
        @(negedge clk);
        A = 64'hFFFF_0000_FFFF_0000; B = 64'd4; arith = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (S !== 64'h0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: S=%h busy=%b done=%b, want 0/0/0", S, busy, done);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) seen++;
        end
        checks++;
        if (seen != 0 || S !== 64'h0) begin
            errors++;
            $display("FAIL no_done_after_reset: done seen %0d times S=%h, want 0 and 0", seen, S);
        end
        do_op(64'h0000_0000_0000_0100, 64'd8, 1'b0, 1'b0, s, lat);
        checks++;
        if (s !== 64'h1 || lat != 6) begin
            errors++;
            $display("FAIL op_after_reset: S=%h lat=%0d, want 1 lat 6", s, lat);
        end
    endtask

    task automatic test_sweep();
        logic [63:0] a;
        logic [63:0] s;
        logic [63:0] exp;
        int lat;
        a = 64'hA5A5_5A5A_F00F_0FF0;
        for (int ar = 0; ar < 2; ar++) begin
            for (int b = 0; b < 64; b++) begin
                do_op(a, 64'(b), ar[0], 1'b0, s, lat);
                exp = (ar == 1) ? 64'($signed(a) >>> b) : (a >> b);
                checks++;
                if (s !== exp || lat != 6) begin
                    errors++;
                    $display("FAIL sweep arith=%0d B=%0d: S=%h lat=%0d, want %h lat 6",
                             ar, b, s, lat, exp);
                end
            end
        end
    endtask

`ifdef RSHIFT_WORD_OP_EN
    task automatic test_word();
        logic [63:0] s;
        int lat;
        do_op(64'h0000_0000_8000_0000, 64'd4, 1'b1, 1'b1, s, lat);
        checks++;
        if (s !== 64'hFFFF_FFFF_F800_0000 || lat != 6) begin
            errors++;
            $display("FAIL sraw_4: S=%h lat=%0d, want fffffffff8000000 lat 6", s, lat);
        end
        do_op(64'h0000_0000_8000_0000, 64'd36, 1'b0, 1'b1, s, lat);
        checks++;
        if (s !== 64'h0000_0000_0800_0000 || lat != 6) begin
            errors++;
            $display("FAIL srlw_36: S=%h lat=%0d, want 0000000008000000 lat 6", s, lat);
        end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_ignore_busy();
        test_back_to_back();
        test_async_reset();
        test_sweep();
`ifdef RSHIFT_WORD_OP_EN
        test_word();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
